zeroriscy_ppu_issue: RTL

- EX-stage issue/retire unit for the custom posit (PPU) instructions.
- Takes decoded ppu_operator and operands from ID for OPCODE_PPU_OP and OPCODE_PPU_OPIMM.
- Drives a valid/ready request and a response channel to the multi-cycle PPU core.
- Stalls EX until the result returns, then returns a registered result for writeback. Handles flush, timeout and illegal operator codes.

---
 rtl/zeroriscy_ppu_issue.sv | 107 ++++++++++
 1 files changed

// File: rtl/zeroriscy_ppu_issue.sv
// zeroriscy_ppu_issue: EX-stage issue/retire unit for posit (PPU) instructions.
// Issues one request to the multi-cycle PPU, stalls EX until the response, then retires it.
module zeroriscy_ppu_issue #(
    parameter int PPU_OP_WIDTH   = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ppu_en_i,
    input  logic [PPU_OP_WIDTH-1:0] ppu_operator_i,
    input  logic [DATA_WIDTH-1:0]   operand_a_i,
    input  logic [DATA_WIDTH-1:0]   operand_b_i,
    input  logic                    kill_i,
    output logic                    ex_ready_o,
    output logic [DATA_WIDTH-1:0]   ppu_result_o,
    output logic                    ppu_result_valid_o,
    output logic                    illegal_op_o,
    output logic                    timeout_o,
    output logic                    ppu_valid_o,
    input  logic                    ppu_ready_i,
    output logic [PPU_OP_WIDTH-1:0] ppu_op_o,
    output logic [DATA_WIDTH-1:0]   ppu_a_o,
    output logic [DATA_WIDTH-1:0]   ppu_b_o,
    input  logic                    ppu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   ppu_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [7:0]              r_cnt;
    logic [7:0]              w_cnt_inc;
    logic                    r_result_valid;
    logic                    r_illegal;
    logic                    r_timeout;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [PPU_OP_WIDTH-1:0] r_op;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic                    w_take;
    logic                    w_legal;
    logic                    w_hs;
    logic                    w_retire;
    logic                    w_tmo;

    // The instruction retiring this cycle is still presented by ID, so it must not be taken again.
    assign w_take    = (r_state == IDLE) & ppu_en_i & ~kill_i & ~r_result_valid & ~r_illegal;
    assign w_legal   = ppu_operator_i <= PPU_OP_WIDTH'(5);
    assign w_hs      = (r_state == REQ) & ppu_ready_i;
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_retire  = (r_state == WAIT) & ppu_rvalid_i & ~kill_i;
    assign w_tmo     = (r_state == WAIT) & ~ppu_rvalid_i & ~kill_i & (w_cnt_inc == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_take & w_legal) ? REQ : IDLE;
            REQ:     w_next = w_hs ? (kill_i ? DRAIN : WAIT) : (kill_i ? IDLE : REQ);
            WAIT:    w_next = ppu_rvalid_i ? IDLE : ((kill_i | w_tmo) ? DRAIN : WAIT);
            DRAIN:   w_next = ppu_rvalid_i ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_result_valid <= 1'b0;
            r_illegal      <= 1'b0;
            r_timeout      <= 1'b0;
            r_result       <= '0;
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
        end else begin
            r_state        <= w_next;
            r_result_valid <= w_retire | w_tmo;
            r_illegal      <= w_take & ~w_legal;
            r_timeout      <= w_tmo;
            if (w_hs)
                r_cnt <= '0;
            else if (r_state == WAIT)
                r_cnt <= w_cnt_inc;
            if (w_retire)
                r_result <= ppu_rdata_i;
            else if (w_tmo)
                r_result <= '0;
            if (w_take & w_legal) begin
                r_op <= ppu_operator_i;
                r_a  <= operand_a_i;
                r_b  <= operand_b_i;
            end
        end
    end

    assign ex_ready_o         = ((r_state == IDLE) & ~ppu_en_i) | r_result_valid | r_illegal;
    assign ppu_valid_o        = (r_state == REQ);
    assign ppu_op_o           = r_op;
    assign ppu_a_o            = r_a;
    assign ppu_b_o            = r_b;
    assign ppu_result_o       = r_result;
    assign ppu_result_valid_o = r_result_valid;
    assign illegal_op_o       = r_illegal;
    assign timeout_o          = r_timeout;
endmodule
